// File: rtl/divideby_pkg.sv
// rtl/divideby_pkg.sv - shared state and mode types for the divide-by-N FSM
package divideby_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  typedef enum logic {
    PULSE  = 1'b0,
    SQUARE = 1'b1
  } mode_t;

endpackage

// File: rtl/divideby_n_fsm_if.sv
// rtl/divideby_n_fsm_if.sv - control and output bundle of the divide-by-N FSM
interface divideby_n_fsm_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic             mode;
  logic             y;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic [1:0]       state;

  modport master (
    output en, clr, load, div_in, mode,
    input  y, tick, cnt, state
  );

  modport slave (
    input  en, clr, load, div_in, mode,
    output y, tick, cnt, state
  );

endinterface

// File: rtl/div_shadow.sv
// rtl/div_shadow.sv - pending divisor/mode shadow register with transfer to active
module div_shadow
  import divideby_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  input  logic             xfer,
  output logic [WIDTH-1:0] div_act,
  output mode_t            mode_act
);

  logic [WIDTH-1:0] pend_div;
  logic             pend_flag;
  logic             load_ok;

  // A zero divisor is meaningless and clr wins over a same-cycle load.
  assign load_ok = load && (div_in != '0) && !clr;

  // At a transfer point a same-cycle load bypasses the pending register so
  // it governs the very next period; otherwise loads wait in the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_div  <= '0;
      pend_flag <= 1'b0;
      div_act   <= WIDTH'(RESET_DIV);
      mode_act  <= PULSE;
    end else if (xfer) begin
      if (load_ok)
        div_act <= div_in;
      else if (pend_flag)
        div_act <= pend_div;
      mode_act  <= mode_t'(mode_in);
      pend_flag <= 1'b0;
    end else if (load_ok) begin
      pend_div  <= div_in;
      pend_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/divideby_n_fsm.sv
// rtl/divideby_n_fsm.sv - run/hold/idle divide-by-N counter with pulse or square output
module divideby_n_fsm
  import divideby_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  divideby_n_fsm_if.slave   bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] last_cnt;
  mode_t            mode_act;
  logic             at_last;
  logic             wrap;
  logic             xfer;
  logic [WIDTH:0]   half;

  assign last_cnt = div_act - WIDTH'(1);
  assign at_last  = (cnt_q == last_cnt);
  // A wrap only happens when the counter actually advances out of the last phase.
  assign wrap     = (state_q == RUN) && bus.en && at_last && !bus.clr;
  assign xfer     = bus.clr || (state_q == IDLE) || wrap;
  assign half     = ({1'b0, div_act} + (WIDTH+1)'(1)) >> 1;

  div_shadow #(
    .WIDTH     (WIDTH),
    .RESET_DIV (RESET_DIV)
  ) u_shadow (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bus.clr),
    .load     (bus.load),
    .div_in   (bus.div_in),
    .mode_in  (bus.mode),
    .xfer     (xfer),
    .div_act  (div_act),
    .mode_act (mode_act)
  );

  // State and phase counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next count; the counter advances only while staying in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.en) state_d = RUN;
        end
        RUN: begin
          if (bus.en)
            cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
          else
            state_d = HOLD;
        end
        HOLD: begin
          if (bus.en) state_d = RUN;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore decode of y and tick from registered state, count and active settings.
  always_comb begin
    bus.y    = 1'b0;
    bus.tick = 1'b0;
    if (state_q == RUN) begin
      bus.tick = at_last;
      if (mode_act == PULSE)
        bus.y = (cnt_q == '0);
      else
        bus.y = ({1'b0, cnt_q} < half);
    end
  end

  assign bus.cnt   = cnt_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_divideby_n_fsm.sv
// tb/tb_divideby_n_fsm.sv - directed self-checking bench for divideby_n_fsm
module tb_divideby_n_fsm;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  divideby_n_fsm_if #(.WIDTH(WIDTH)) bus ();

  divideby_n_fsm #(
    .WIDTH     (WIDTH),
    .RESET_DIV (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.en     = 1'b1;
    bus.clr    = 1'b0;
    bus.load   = 1'b0;
    bus.div_in = '0;
    bus.mode   = 1'b0;
    step();
    step();
    total_cnt++;
    if (bus.state !== 2'b00) $display("FAIL reset_state got %b want 00", bus.state); else pass_cnt++;
    total_cnt++;
    if (bus.cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", bus.cnt); else pass_cnt++;
    total_cnt++;
    if (bus.y !== 1'b0) $display("FAIL reset_y got %b want 0", bus.y); else pass_cnt++;
    total_cnt++;
    if (bus.tick !== 1'b0) $display("FAIL reset_tick got %b want 0", bus.tick); else pass_cnt++;
    bus.en = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    total_cnt++;
    if (bus.state !== 2'b00) $display("FAIL release_idle got %b want 00", bus.state); else pass_cnt++;
  endtask

  task automatic test_pulse_n3();
    bus.mode = 1'b0;
    bus.en   = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      total_cnt++;
      if (bus.cnt !== 8'(i % 3)) $display("FAIL pulse_cnt[%0d] got %0d want %0d", i, bus.cnt, i % 3); else pass_cnt++;
      total_cnt++;
      if (bus.y !== ((i % 3) == 0)) $display("FAIL pulse_y[%0d] got %b want %b", i, bus.y, (i % 3) == 0); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== ((i % 3) == 2)) $display("FAIL pulse_tick[%0d] got %b want %b", i, bus.tick, (i % 3) == 2); else pass_cnt++;
      step();
    end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    total_cnt++;
    if (bus.state !== 2'b00) $display("FAIL clr_state got %b want 00", bus.state); else pass_cnt++;
    total_cnt++;
    if (bus.cnt !== 8'd0) $display("FAIL clr_cnt got %0d want 0", bus.cnt); else pass_cnt++;
    total_cnt++;
    if (bus.y !== 1'b0) $display("FAIL clr_y got %b want 0", bus.y); else pass_cnt++;
  endtask

  task automatic test_square_n5();
    bus.load   = 1'b1;
    bus.div_in = 8'd5;
    bus.mode   = 1'b1;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (bus.y !== ((i % 5) < 3)) $display("FAIL square_y[%0d] got %b want %b", i, bus.y, (i % 5) < 3); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== ((i % 5) == 4)) $display("FAIL square_tick[%0d] got %b want %b", i, bus.tick, (i % 5) == 4); else pass_cnt++;
      step();
    end
    bus.clr  = 1'b1;
    bus.mode = 1'b0;
    step();
    bus.clr = 1'b0;
    bus.en  = 1'b0;
  endtask

  task automatic test_load_changes();
    int exp_c [15] = '{0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 0, 1, 2, 3, 0};
    int exp_t [15] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0};
    int ld    [15] = '{0, 4, 0, 0, 7, 3, 0, 0, 0, 4, 0, 0, 0, 0, 0};
    bus.load   = 1'b1;
    bus.div_in = 8'd3;
    bus.mode   = 1'b0;
    bus.en     = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      total_cnt++;
      if (bus.cnt !== 8'(exp_c[k])) $display("FAIL load_cnt[%0d] got %0d want %0d", k, bus.cnt, exp_c[k]); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== 1'(exp_t[k])) $display("FAIL load_tick[%0d] got %b want %0d", k, bus.tick, exp_t[k]); else pass_cnt++;
      bus.load   = (ld[k] != 0);
      bus.div_in = 8'(ld[k]);
      step();
    end
    bus.load = 1'b0;
    bus.clr  = 1'b1;
    step();
    bus.clr = 1'b0;
    bus.en  = 1'b0;
  endtask

  task automatic test_hold();
    bus.load   = 1'b1;
    bus.div_in = 8'd3;
    bus.en     = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    step();
    total_cnt++;
    if (bus.cnt !== 8'd2) $display("FAIL hold_pre_cnt got %0d want 2", bus.cnt); else pass_cnt++;
    bus.en = 1'b0;
    step();
    for (int j = 0; j < 5; j++) begin
      total_cnt++;
      if (bus.state !== 2'b10) $display("FAIL hold_state[%0d] got %b want 10", j, bus.state); else pass_cnt++;
      total_cnt++;
      if (bus.cnt !== 8'd2) $display("FAIL hold_cnt[%0d] got %0d want 2", j, bus.cnt); else pass_cnt++;
      total_cnt++;
      if (bus.y !== 1'b0) $display("FAIL hold_y[%0d] got %b want 0", j, bus.y); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== 1'b0) $display("FAIL hold_tick[%0d] got %b want 0", j, bus.tick); else pass_cnt++;
      step();
    end
    bus.en = 1'b1;
    step();
    total_cnt++;
    if (bus.state !== 2'b01) $display("FAIL resume_state got %b want 01", bus.state); else pass_cnt++;
    total_cnt++;
    if (bus.cnt !== 8'd2) $display("FAIL resume_cnt got %0d want 2", bus.cnt); else pass_cnt++;
    total_cnt++;
    if (bus.tick !== 1'b1) $display("FAIL resume_tick got %b want 1", bus.tick); else pass_cnt++;
    step();
    total_cnt++;
    if (bus.cnt !== 8'd0) $display("FAIL resume_wrap_cnt got %0d want 0", bus.cnt); else pass_cnt++;
    total_cnt++;
    if (bus.y !== 1'b1) $display("FAIL resume_wrap_y got %b want 1", bus.y); else pass_cnt++;
  endtask

  task automatic test_load_zero();
    bus.load   = 1'b1;
    bus.div_in = 8'd5;
    step();
    bus.div_in = 8'd0;
    step();
    bus.load = 1'b0;
    total_cnt++;
    if (bus.tick !== 1'b1) $display("FAIL zero_pre_tick got %b want 1", bus.tick); else pass_cnt++;
    step();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (bus.cnt !== 8'(i)) $display("FAIL zero_cnt[%0d] got %0d want %0d", i, bus.cnt, i); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== (i == 4)) $display("FAIL zero_tick[%0d] got %b want %b", i, bus.tick, i == 4); else pass_cnt++;
      step();
    end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    total_cnt++;
    if (bus.state !== 2'b00) $display("FAIL zero_clr_state got %b want 00", bus.state); else pass_cnt++;
  endtask

  task automatic test_n1_and_async_reset();
    bus.load   = 1'b1;
    bus.div_in = 8'd1;
    bus.mode   = 1'b0;
    bus.en     = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.y !== 1'b1) $display("FAIL n1_pulse_y[%0d] got %b want 1", i, bus.y); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== 1'b1) $display("FAIL n1_pulse_tick[%0d] got %b want 1", i, bus.tick); else pass_cnt++;
      step();
    end
    bus.mode = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.y !== 1'b1) $display("FAIL n1_square_y[%0d] got %b want 1", i, bus.y); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== 1'b1) $display("FAIL n1_square_tick[%0d] got %b want 1", i, bus.tick); else pass_cnt++;
      step();
    end
    #3;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.state !== 2'b00) $display("FAIL async_state got %b want 00", bus.state); else pass_cnt++;
    total_cnt++;
    if (bus.cnt !== 8'd0) $display("FAIL async_cnt got %0d want 0", bus.cnt); else pass_cnt++;
    total_cnt++;
    if (bus.y !== 1'b0) $display("FAIL async_y got %b want 0", bus.y); else pass_cnt++;
    total_cnt++;
    if (bus.tick !== 1'b0) $display("FAIL async_tick got %b want 0", bus.tick); else pass_cnt++;
    bus.en   = 1'b0;
    bus.mode = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b1;
    step();
    total_cnt++;
    if (bus.state !== 2'b00) $display("FAIL post_reset_idle got %b want 00", bus.state); else pass_cnt++;
    bus.en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (bus.cnt !== 8'(i % 3)) $display("FAIL post_reset_cnt[%0d] got %0d want %0d", i, bus.cnt, i % 3); else pass_cnt++;
      total_cnt++;
      if (bus.tick !== ((i % 3) == 2)) $display("FAIL post_reset_tick[%0d] got %b want %b", i, bus.tick, (i % 3) == 2); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_pulse_n3();
    test_square_n5();
    test_load_changes();
    test_hold();
    test_load_zero();
    test_n1_and_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/divideby_n_fsm.md
DIVIDEBY_N_FSM -- requirements
Module: divideby_n_fsm

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, divisor and counter width.
REQ-002 SHALL provide parameter RESET_DIV, default 3, active divisor after reset (legal range 1..2^WIDTH-1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, run request; high = count, low = pause.
REQ-006 SHALL have port clr, input, 1, synchronous clear to IDLE.
REQ-007 SHALL have port load, input, 1, capture div_in into the pending-divisor register.
REQ-008 SHALL have port div_in, input, WIDTH, new divisor N.
REQ-009 SHALL have port mode, input, 1, 0 = pulse output, 1 = square output.
REQ-010 SHALL have port y, output, 1, divided output.
REQ-011 SHALL have port tick, output, 1, terminal-count strobe.
REQ-012 SHALL have port cnt, output, WIDTH, current phase count.
REQ-013 SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-014 SHALL implement FSM states IDLE=2'b00, RUN=2'b01, HOLD=2'b10; 2'b11 SHALL recover to IDLE on the next clock.
REQ-015 SHALL use these transitions: IDLE->RUN on en; RUN->HOLD on !en; HOLD->RUN on en; any state->IDLE on clr.
REQ-016 SHALL give clr priority over en and load in the same cycle.
REQ-017 SHALL, in RUN only, count cnt 0,1,...,div_act-1 then wrap to 0, where div_act is the active divisor.
REQ-018 SHALL hold cnt at 0 in IDLE and freeze cnt in HOLD, resuming from the frozen value on HOLD->RUN.
REQ-019 SHALL decode y and tick combinationally from registered state, cnt, div_act and mode_act (Moore outputs, zero-cycle latency from state).
REQ-020 SHALL drive y, in pulse mode, as state==RUN && cnt==0, giving one high cycle per N cycles.
REQ-021 SHALL drive y, in square mode, as state==RUN && cnt < ceil(div_act/2); for N=3, y is high 2 cycles and low 1 cycle.
REQ-022 SHALL drive tick as state==RUN && cnt==div_act-1.
REQ-023 SHALL ignore load when div_in==0; the pending register and its flag SHALL then be unchanged.
REQ-024 SHALL treat N=1 as y and tick constantly high while in RUN, in both modes.
REQ-025 SHALL transfer the pending divisor and the mode input into div_act and mode_act only at a wrap (tick high in RUN), in IDLE, or on clr, so a period is never truncated.
REQ-026 SHALL, when load and tick coincide, make div_in active for the period starting at the next cnt=0.
REQ-027 SHALL, when a second load arrives before the transfer, keep only the last value.
REQ-028 SHALL clear the pending flag when the transfer occurs.

Reset
REQ-029 SHALL, on reset_n low, immediately force: state=IDLE, cnt=0, div_act=RESET_DIV, mode_act=0, pending flag=0, y=0, tick=0.
REQ-030 SHALL apply reset mid-operation at once, with no completion of the current period.
REQ-031 SHALL release reset synchronously to clk and enter RUN no earlier than the first edge with en high.

Structure
REQ-032 SHALL place the state enum typedef (logic [1:0] IDLE/RUN/HOLD) and the mode enum (PULSE/SQUARE) in shared package divideby_pkg.
REQ-033 SHALL implement the pending-divisor/mode shadow register plus flag as sub-module div_shadow; the FSM and counter SHALL stay in the top module.

Verification
REQ-034 SHALL cover: reset, en=1, default N=3, pulse mode -> y high on cycles 0,3,6 of RUN; tick on cycles 2,5,8.
REQ-035 SHALL cover: N=5, square mode -> y pattern 1,1,1,0,0 repeating; tick on cnt=4.
REQ-036 SHALL cover: load div_in=4 at cnt=1 of an N=3 period -> the current period completes as 3 cycles, then the period is 4; same-cycle load+tick -> the next period is 4.
REQ-037 SHALL cover: en low at cnt=2 for 5 cycles -> state=HOLD, cnt frozen at 2, y/tick follow the decode; en high -> resumes at 2.
REQ-038 SHALL cover: load div_in=0 -> ignored; clr during RUN -> IDLE, cnt=0, y=0 next cycle.
REQ-039 SHALL cover: reset_n low mid-period -> all outputs 0 immediately, without waiting for a clock edge.
